// File: rtl/wb_stage.sv
// Write-back pipeline stage: latches the MEM result, drives register-file writes,
// owns the HI/LO registers, and counts retired instructions when WB_RETIRE_CNT_EN is defined.
module wb_stage (
  input  logic         clk,
  input  logic         rst,
  input  logic [5:0]   stall,
  input  logic [136:0] mem_to_wb_bus,
  output logic [37:0]  wb_to_rf_bus,
  output logic [37:0]  wb_to_id_forwarding,
  output logic [31:0]  hi_rdata,
  output logic [31:0]  lo_rdata,
  output logic [31:0]  debug_wb_pc,
  output logic [3:0]   debug_wb_rf_wen,
  output logic [4:0]   debug_wb_rf_wnum,
  output logic [31:0]  debug_wb_rf_wdata,
  output logic [31:0]  retire_cnt
);

  logic [136:0] stage_reg, stage_next;
  logic         valid_reg, valid_next;
  logic [31:0]  hi_reg, hi_next;
  logic [31:0]  lo_reg, lo_next;

  logic         lo_wen, hi_wen, hilo_sel, rf_we, rf_we_eff, hold;
  logic [63:0]  hilo_res;
  logic [31:0]  pc, rf_wdata, hilo_wval_hi, hilo_wval_lo;
  logic [4:0]   rf_waddr;
  logic         unused_stall;

  assign {lo_wen, hi_wen, hilo_sel, hilo_res, pc, rf_we, rf_waddr, rf_wdata} = stage_reg;

  assign hold         = stall[4] & stall[5];
  assign unused_stall = ^stall[3:0];

  always_comb begin
    stage_next = stage_reg;
    valid_next = valid_reg;
    if (!stall[4]) begin
      stage_next = mem_to_wb_bus;
      valid_next = |mem_to_wb_bus;
    end else if (!stall[5]) begin
      stage_next = '0;
      valid_next = 1'b0;
    end
  end

  // hi_next/lo_next double as the zero-latency bypass seen on hi_rdata/lo_rdata.
  assign hilo_wval_hi = hilo_sel ? hilo_res[63:32] : rf_wdata;
  assign hilo_wval_lo = hilo_sel ? hilo_res[31:0]  : rf_wdata;
  assign hi_next      = (valid_reg && hi_wen) ? hilo_wval_hi : hi_reg;
  assign lo_next      = (valid_reg && lo_wen) ? hilo_wval_lo : lo_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_reg <= '0;
      valid_reg <= 1'b0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      stage_reg <= stage_next;
      valid_reg <= valid_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
    end
  end

  assign rf_we_eff           = rf_we & valid_reg;
  assign wb_to_rf_bus        = {rf_we_eff, rf_waddr, rf_wdata};
  assign wb_to_id_forwarding = {rf_we_eff, rf_waddr, rf_wdata};
  assign hi_rdata            = hi_next;
  assign lo_rdata            = lo_next;
  assign debug_wb_pc         = pc;
  assign debug_wb_rf_wnum    = rf_waddr;
  assign debug_wb_rf_wdata   = rf_wdata;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dbg_wen
    assign debug_wb_rf_wen[gi] = rf_we_eff;
  end

`ifdef WB_RETIRE_CNT_EN
  // A held instruction retires once, on the edge where it finally leaves the stage.
  logic [31:0] retire_cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retire_cnt_reg <= '0;
    end else if (valid_reg && !hold) begin
      retire_cnt_reg <= retire_cnt_reg + 32'd1;
    end
  end

  assign retire_cnt = retire_cnt_reg;
`else
  logic unused_hold;
  assign unused_hold = hold;
  assign retire_cnt  = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed vector table, reset/hold sequences, and randomized
// traffic against a field-level reference model. Honours WB_RETIRE_CNT_EN.
module tb_wb_stage;

  typedef struct packed {
    logic        lo_wen;
    logic        hi_wen;
    logic        sel;
    logic [63:0] res;
    logic [31:0] pc;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
  } instr_t;

  typedef struct {
    logic [5:0]  stall;
    instr_t      in;
    logic [37:0] rf;
    logic [31:0] pc;
    logic [3:0]  wen;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] cnt;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [5:0]   stall = '0;
  logic [136:0] mem_to_wb_bus = '0;
  logic [37:0]  wb_to_rf_bus, wb_to_id_forwarding;
  logic [31:0]  hi_rdata, lo_rdata, debug_wb_pc, debug_wb_rf_wdata, retire_cnt;
  logic [3:0]   debug_wb_rf_wen;
  logic [4:0]   debug_wb_rf_wnum;

  int errors = 0;
  int checks = 0;

  wb_stage dut (
    .clk                 (clk),
    .rst                 (rst),
    .stall               (stall),
    .mem_to_wb_bus       (mem_to_wb_bus),
    .wb_to_rf_bus        (wb_to_rf_bus),
    .wb_to_id_forwarding (wb_to_id_forwarding),
    .hi_rdata            (hi_rdata),
    .lo_rdata            (lo_rdata),
    .debug_wb_pc         (debug_wb_pc),
    .debug_wb_rf_wen     (debug_wb_rf_wen),
    .debug_wb_rf_wnum    (debug_wb_rf_wnum),
    .debug_wb_rf_wdata   (debug_wb_rf_wdata),
    .retire_cnt          (retire_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state: the instruction sitting in WB plus architectural HI/LO/count.
  instr_t      m_ins;
  logic        m_valid;
  logic [31:0] m_hi, m_lo, m_cnt;

  function automatic logic [31:0] cnt_view(input logic [31:0] c);
`ifdef WB_RETIRE_CNT_EN
    return c;
`else
    return 32'd0 & c;
`endif
  endfunction

  function automatic instr_t mk(input logic lo_wen, input logic hi_wen, input logic sel,
                                input logic [63:0] res, input logic [31:0] pc,
                                input logic we, input logic [4:0] wa, input logic [31:0] wd);
    instr_t r;
    r.lo_wen = lo_wen; r.hi_wen = hi_wen; r.sel = sel; r.res = res;
    r.pc = pc; r.we = we; r.wa = wa; r.wd = wd;
    return r;
  endfunction

  function automatic instr_t rand_instr();
    instr_t r;
    r = mk($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
           {$urandom(), $urandom()}, $urandom(), $urandom_range(0, 1),
           5'($urandom_range(0, 31)), $urandom());
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [37:0] rf, input logic [31:0] pc,
                               input logic [3:0] wen, input logic [31:0] hi,
                               input logic [31:0] lo, input logic [31:0] cnt);
    chk({tag, ".rf_bus"}, 64'(wb_to_rf_bus), 64'(rf));
    chk({tag, ".fwd_bus"}, 64'(wb_to_id_forwarding), 64'(rf));
    chk({tag, ".hi"}, 64'(hi_rdata), 64'(hi));
    chk({tag, ".lo"}, 64'(lo_rdata), 64'(lo));
    chk({tag, ".dbg_pc"}, 64'(debug_wb_pc), 64'(pc));
    chk({tag, ".dbg_wen"}, 64'(debug_wb_rf_wen), 64'(wen));
    chk({tag, ".dbg_wnum"}, 64'(debug_wb_rf_wnum), 64'(rf[36:32]));
    chk({tag, ".dbg_wdata"}, 64'(debug_wb_rf_wdata), 64'(rf[31:0]));
    chk({tag, ".retire_cnt"}, 64'(retire_cnt), 64'(cnt_view(cnt)));
  endtask

  task automatic step(input logic [5:0] s, input instr_t in);
    @(negedge clk);
    stall = s;
    mem_to_wb_bus = in;
    @(posedge clk);
    #1;
  endtask

  // One rising edge of the architecture: commit HI/LO, retire, then advance the stage.
  task automatic model_edge(input logic [5:0] s, input instr_t in);
    if (m_valid && m_ins.hi_wen) m_hi = m_ins.sel ? m_ins.res[63:32] : m_ins.wd;
    if (m_valid && m_ins.lo_wen) m_lo = m_ins.sel ? m_ins.res[31:0] : m_ins.wd;
    if (m_valid && !(s[4] && s[5])) m_cnt = m_cnt + 32'd1;
    if (!s[4]) begin
      m_ins = in;
      m_valid = (in != '0);
    end else if (!s[5]) begin
      m_ins = '0;
      m_valid = 1'b0;
    end
  endtask

  task automatic model_check(input string tag);
    logic        we;
    logic [31:0] hi, lo;
    we = m_ins.we & m_valid;
    hi = (m_valid && m_ins.hi_wen) ? (m_ins.sel ? m_ins.res[63:32] : m_ins.wd) : m_hi;
    lo = (m_valid && m_ins.lo_wen) ? (m_ins.sel ? m_ins.res[31:0] : m_ins.wd) : m_lo;
    check_outputs(tag, {we, m_ins.wa, m_ins.wd}, m_ins.pc, {4{we}}, hi, lo, m_cnt);
  endtask

  vec_t tbl[9];

  initial begin
    // Directed table: each row is applied for one edge, outputs checked just after it.
    tbl[0] = '{6'b000000, mk(0,0,0,64'h0,32'hBFC00000,1,5'd5,32'h12345678),
               {1'b1,5'd5,32'h12345678}, 32'hBFC00000, 4'hF, 32'h0, 32'h0, 32'd0};
    tbl[1] = '{6'b000000, mk(1,1,1,64'h00000001_FFFFFFFE,32'hBFC00004,0,5'd0,32'h0),
               {1'b0,5'd0,32'h0}, 32'hBFC00004, 4'h0, 32'h1, 32'hFFFFFFFE, 32'd1};
    tbl[2] = '{6'b000000, mk(1,0,0,64'h0,32'hBFC00008,0,5'd0,32'hCAFEF00D),
               {1'b0,5'd0,32'hCAFEF00D}, 32'hBFC00008, 4'h0, 32'h1, 32'hCAFEF00D, 32'd2};
    tbl[3] = '{6'b010000, rand_instr(),
               38'h0, 32'h0, 4'h0, 32'h1, 32'hCAFEF00D, 32'd3};
    tbl[4] = '{6'b000000, mk(0,1,0,64'h0,32'h00000100,1,5'd31,32'hDEADBEEF),
               {1'b1,5'd31,32'hDEADBEEF}, 32'h00000100, 4'hF, 32'hDEADBEEF, 32'hCAFEF00D, 32'd3};
    tbl[5] = '{6'b110000, rand_instr(),
               {1'b1,5'd31,32'hDEADBEEF}, 32'h00000100, 4'hF, 32'hDEADBEEF, 32'hCAFEF00D, 32'd3};
    tbl[6] = tbl[5];
    tbl[6].in = rand_instr();
    tbl[7] = tbl[5];
    tbl[7].in = rand_instr();
    tbl[8] = '{6'b000000, instr_t'('0),
               38'h0, 32'h0, 4'h0, 32'hDEADBEEF, 32'hCAFEF00D, 32'd4};

    #2;
    check_outputs("reset", 38'h0, 32'h0, 4'h0, 32'h0, 32'h0, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].stall, tbl[i].in);
      $display("vec %0d stall=%b rf_bus=%h hi=%h lo=%h cnt=%0d", i, tbl[i].stall,
               wb_to_rf_bus, hi_rdata, lo_rdata, retire_cnt);
      check_outputs($sformatf("vec%0d", i), tbl[i].rf, tbl[i].pc, tbl[i].wen,
                    tbl[i].hi, tbl[i].lo, tbl[i].cnt);
    end

    // Reset between edges while an HI writer is held in the stage.
    step(6'b000000, mk(0,1,0,64'h0,32'h200,0,5'd0,32'h55));
    chk("hi_bypass_55", 64'(hi_rdata), 64'h55);
    step(6'b110000, rand_instr());
    chk("hi_held_55", 64'(hi_rdata), 64'h55);
    chk("hi_held_rf", 64'(wb_to_rf_bus), 64'({1'b0,5'd0,32'h55}));
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    $display("async reset: hi=%h cnt=%0d rf_bus=%h", hi_rdata, retire_cnt, wb_to_rf_bus);
    check_outputs("async_rst", 38'h0, 32'h0, 4'h0, 32'h0, 32'h0, 32'd0);
    @(posedge clk);
    #1;
    check_outputs("rst_hold", 38'h0, 32'h0, 4'h0, 32'h0, 32'h0, 32'd0);

    // First edge after release must already capture.
    @(negedge clk);
    rst = 1'b1;
    stall = 6'b000000;
    mem_to_wb_bus = mk(0,0,0,64'h0,32'h300,1,5'd3,32'h77);
    @(posedge clk);
    #1;
    $display("first capture: rf_bus=%h pc=%h", wb_to_rf_bus, debug_wb_pc);
    check_outputs("first_cap", {1'b1,5'd3,32'h77}, 32'h300, 4'hF, 32'h0, 32'h0, 32'd0);

`ifdef WB_RETIRE_CNT_EN
    @(negedge clk);
    force dut.retire_cnt_reg = 32'hFFFFFFFF;
    #1;
    release dut.retire_cnt_reg;
    stall = 6'b000000;
    mem_to_wb_bus = '0;
    @(posedge clk);
    #1;
    $display("wrap: retire_cnt=%h", retire_cnt);
    chk("cnt_wrap", 64'(retire_cnt), 64'h0);
`endif

    // Randomized traffic against the reference model, from a fresh reset.
    @(negedge clk);
    rst = 1'b0;
    #1;
    rst = 1'b1;
    m_ins = '0; m_valid = 1'b0; m_hi = '0; m_lo = '0; m_cnt = '0;
    for (int n = 0; n < 300; n++) begin
      logic [5:0] s;
      instr_t     in;
      s = 6'($urandom());
      if ($urandom_range(0, 2) == 0) s[4] = 1'b0;
      in = ($urandom_range(0, 7) == 0) ? instr_t'('0) : rand_instr();
      step(s, in);
      model_edge(s, in);
      $display("rnd %0d stall=%b rf_bus=%h hi=%h lo=%h cnt=%0d", n, s,
               wb_to_rf_bus, hi_rdata, lo_rdata, retire_cnt);
      model_check($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
